tme_frame_sequencer: RTL and testbench
======================================

TME_FRAME_SEQUENCER -- requirements
Module: tme_frame_sequencer

Interface
REQ-001 Parameter IMG_W, default 640, pixels per row.
REQ-002 Parameter IMG_H, default 480, rows per frame.
REQ-003 Parameter LAT, default 3, cycles from dp_load to dp_tx valid.
REQ-004 Parameter FIFO_DEPTH, default 4, result buffer entries (power of two, >= LAT+1).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 start  in  1  one-cycle frame start request.
REQ-008 mode_en  in  1  estimation mode; sampled on accepted start.
REQ-009 a_valid  in  1  atmospheric-light triple valid.
REQ-010 a_r, a_g, a_b  in  8 each  local atmospheric light per channel.
REQ-011 win_valid  in  1  3x3 RGB window available upstream.
REQ-012 win_ready  out  1  sequencer accepts a window this cycle.
REQ-013 dp_load  out  1  window presented to estimation datapath this cycle.
REQ-014 dp_en  out  1  mode to datapath, held for whole frame.
REQ-015 dp_ar, dp_ag, dp_ab  out  8 each  latched atmospheric light to datapath.
REQ-016 dp_tx  in  12  datapath inverse transmission result.
REQ-017 out_valid / out_ready  out / in  1 / 1  result stream handshake.
REQ-018 out_tx  out  12  buffered result; out_last  out  1  final pixel of frame.
REQ-019 busy  out  1  state != IDLE; frame_done  out  1  one-cycle end-of-frame pulse.

Function
REQ-020 FSM states IDLE, LOAD_A, RUN, DRAIN, DONE.
REQ-021 IDLE->LOAD_A on start; start in any other state is ignored.
REQ-022 LOAD_A: on a_valid capture a_r/a_g/a_b into dp_ar/dp_ag/dp_ab, go RUN; values held until next frame.
REQ-023 dp_en = mode_en sampled on the accepted start cycle.
REQ-024 win_ready = (state==RUN) and (fifo_count + inflight < FIFO_DEPTH); combinational, no dependency on win_valid.
REQ-025 dp_load = win_valid and win_ready.
REQ-026 LAT-bit valid shift register tracks in-flight windows; inflight = popcount of it; last flag shifts alongside.
REQ-027 Result appearing LAT cycles after dp_load is pushed into FIFO with its last flag; FIFO never overflows by construction.
REQ-028 col counts 0..IMG_W-1 per dp_load, wraps to 0 and increments row; row wraps to 0 after IMG_H-1.
REQ-029 Load with col==IMG_W-1 and row==IMG_H-1 marks last; RUN->DRAIN on that cycle.
REQ-030 DRAIN->DONE when inflight==0 and FIFO empty; DONE->IDLE after one cycle, frame_done=1 in DONE only.
REQ-031 out_valid = FIFO non-empty; pop on out_valid and out_ready; simultaneous push and pop keeps count.
REQ-032 out_tx/out_last present FIFO head; stable while out_valid and not out_ready.

Reset
REQ-033 On rst_n=0 at clk edge: state IDLE, counters, FIFO pointers, shift register cleared.
REQ-034 Reset values: win_ready 0, dp_load 0, dp_en 0, dp_ar/ag/ab 0, out_valid 0, out_tx 0, out_last 0, busy 0, frame_done 0.
REQ-035 Reset mid-frame discards in-flight and buffered results; no frame_done issued.

Structure
REQ-036 Shared package holds FSM state enum, default IMG_W/IMG_H/LAT constants, 12-bit tx width.
REQ-037 Result FIFO is one sub-module, tme_result_fifo (data 13 bits: tx plus last).

Verification
REQ-038 IMG_W=4, IMG_H=2, out_ready=1, continuous win_valid -> 8 loads, 8 outputs in order, out_last only on 8th, frame_done one cycle after drain.
REQ-039 out_ready=0 throughout RUN -> exactly FIFO_DEPTH loads then win_ready=0; release -> all 8 results delivered, none lost.
REQ-040 a_r=200, a_g=150, a_b=100, a_valid delayed 5 cycles -> win_ready=0 in LOAD_A; dp_ar/ag/ab=200/150/100 for whole frame.
REQ-041 start pulsed during RUN with mode_en toggled -> ignored; dp_en unchanged; counters unaffected.
REQ-042 rst_n=0 for one cycle after 3 loads -> all outputs at reset values next cycle; new start yields full fresh frame of 8 results.

Source files
------------

// File: rtl/tme_frame_sequencer_pkg.sv
// Shared types and defaults for the transmission-estimation frame sequencer.
// Holds the FSM state encoding and the result width.
package tme_frame_sequencer_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int LAT_DEF   = 3;
  localparam int TX_W      = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/tme_result_fifo.sv
// Small power-of-two result buffer; head reads as zero when empty.
// Pop on an empty buffer is ignored.
module tme_result_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 13,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_pop;

  assign w_pop   = i_pop && (r_cnt != '0);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_data  = o_empty ? '0 : r_mem[r_rp];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (i_push && !w_pop) r_cnt <= r_cnt + 1'b1;
      if (!i_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end

endmodule

// File: rtl/tme_frame_sequencer.sv
// Frame sequencer: latches atmospheric light, feeds windows to the
// estimation datapath with credit-based backpressure, buffers results.
module tme_frame_sequencer
  import tme_frame_sequencer_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int LAT        = LAT_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_mode_en,
  input  logic            i_a_valid,
  input  logic [7:0]      i_a_r,
  input  logic [7:0]      i_a_g,
  input  logic [7:0]      i_a_b,
  input  logic            i_win_valid,
  output logic            o_win_ready,
  output logic            o_dp_load,
  output logic            o_dp_en,
  output logic [7:0]      o_dp_ar,
  output logic [7:0]      o_dp_ag,
  output logic [7:0]      o_dp_ab,
  input  logic [TX_W-1:0] i_dp_tx,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [TX_W-1:0] o_out_tx,
  output logic            o_out_last,
  output logic            o_busy,
  output logic            o_frame_done
);

  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [LAT-1:0] r_vld;
  logic [LAT-1:0] r_lst;
  logic          r_dp_en;
  logic [7:0]    r_ar;
  logic [7:0]    r_ag;
  logic [7:0]    r_ab;
  logic [FAW:0]  w_cnt;
  logic          w_empty;
  logic [TX_W:0] w_head;
  logic [31:0]   w_infl;
  logic          w_ready;
  logic          w_load;
  logic          w_last;
  logic          w_accept;

  always_comb begin
    w_infl = '0;
    for (int k = 0; k < LAT; k++) begin
      w_infl = w_infl + 32'(r_vld[k]);
    end
  end

  // Credit check: buffered plus in-flight results must leave room
  assign w_ready  = (r_state == S_RUN) &&
                    ((32'(w_cnt) + w_infl) < 32'(FIFO_DEPTH));
  assign w_load   = i_win_valid && w_ready;
  assign w_last   = w_load && (r_col == COL_MAX) &&
                    (r_row == ROW_MAX);
  assign w_accept = (r_state == S_IDLE) && i_start;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_busy       = (r_state != S_IDLE);
    o_frame_done = (r_state == S_DONE);
    unique case (r_state)
      S_IDLE:   if (i_start)   w_next = S_LOAD_A;
      S_LOAD_A: if (i_a_valid) w_next = S_RUN;
      S_RUN:    if (w_last)    w_next = S_DRAIN;
      S_DRAIN:  if (w_infl == 0 && w_empty) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dp_en <= 1'b0;
      r_ar    <= '0;
      r_ag    <= '0;
      r_ab    <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_vld   <= '0;
      r_lst   <= '0;
    end else begin
      if (w_accept) begin
        r_dp_en <= i_mode_en;
        r_col   <= '0;
        r_row   <= '0;
      end
      if (r_state == S_LOAD_A && i_a_valid) begin
        r_ar <= i_a_r;
        r_ag <= i_a_g;
        r_ab <= i_a_b;
      end
      r_vld <= (r_vld << 1) | LAT'(w_load);
      r_lst <= (r_lst << 1) | LAT'(w_last);
      if (w_load) begin
        if (r_col == COL_MAX) begin
          r_col <= '0;
          r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  tme_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (TX_W + 1)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_vld[LAT-1]),
    .i_data  ({r_lst[LAT-1], i_dp_tx}),
    .i_pop   (i_out_ready),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  assign o_win_ready = w_ready;
  assign o_dp_load   = w_load;
  assign o_dp_en     = r_dp_en;
  assign o_dp_ar     = r_ar;
  assign o_dp_ag     = r_ag;
  assign o_dp_ab     = r_ab;
  assign o_out_valid = !w_empty;
  assign o_out_tx    = w_head[TX_W-1:0];
  assign o_out_last  = w_head[TX_W];

endmodule

// File: tb/tb_tme_frame_sequencer.sv
// Bench for tme_frame_sequencer: vector table, directed corner cases,
// random frames checked against a scoreboard model.
module tb_tme_frame_sequencer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int LAT   = 3;
  localparam int D     = 4;
  localparam int FRAME = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode_en = 1'b0;
  logic a_valid = 1'b0;
  logic [7:0] a_r = '0;
  logic [7:0] a_g = '0;
  logic [7:0] a_b = '0;
  logic win_valid = 1'b0;
  logic out_ready = 1'b1;
  logic win_ready, dp_load, dp_en;
  logic out_valid, out_last, busy, frame_done;
  logic [7:0] dp_ar, dp_ag, dp_ab;
  logic [11:0] dp_tx, out_tx;

  tme_frame_sequencer #(
    .IMG_W(W), .IMG_H(H), .LAT(LAT), .FIFO_DEPTH(D)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_start(start), .i_mode_en(mode_en),
    .i_a_valid(a_valid),
    .i_a_r(a_r), .i_a_g(a_g), .i_a_b(a_b),
    .i_win_valid(win_valid), .o_win_ready(win_ready),
    .o_dp_load(dp_load), .o_dp_en(dp_en),
    .o_dp_ar(dp_ar), .o_dp_ag(dp_ag), .o_dp_ab(dp_ab),
    .i_dp_tx(dp_tx),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_tx(out_tx), .o_out_last(out_last),
    .o_busy(busy), .o_frame_done(frame_done)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Datapath stand-in: loaded payload emerges LAT cycles later
  logic [11:0] pipe [LAT];
  logic [11:0] pay [256];
  assign dp_tx = pipe[LAT-1];

  logic [11:0] q[$];
  int g_idx = 0;
  int m_phase = 0;
  int m_loads = 0;
  int m_pops = 0;
  int m_oidx = 0;
  int n_out = 0;
  logic m_en = 1'b0;
  logic [7:0] m_ar = '0;
  logic [7:0] m_ag = '0;
  logic [7:0] m_ab = '0;
  bit chk_en = 1'b0;

  always @(posedge clk) begin : model
    int ph;
    for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
    pipe[0] <= dp_load ? pay[g_idx[7:0]] : 12'($urandom);
    if (!rst_n) begin
      m_phase = 0;
      q.delete();
      m_loads = 0;
      m_pops = 0;
      m_oidx = 0;
      m_en = 1'b0;
      m_ar = '0;
      m_ag = '0;
      m_ab = '0;
    end else begin
      ph = m_phase;
      case (m_phase)
        0: if (start) begin
          ph = 1;
          m_en = mode_en;
          m_loads = 0;
          m_pops = 0;
          m_oidx = 0;
        end
        1: if (a_valid) begin
          ph = 2;
          m_ar = a_r;
          m_ag = a_g;
          m_ab = a_b;
        end
        2: if (dp_load && m_loads + 1 == FRAME) ph = 3;
        3: if (m_pops == m_loads) ph = 4;
        default: ph = 0;
      endcase
      if (dp_load) begin
        q.push_back(pay[g_idx[7:0]]);
        g_idx++;
        m_loads++;
      end
      if (out_valid && out_ready) m_pops++;
      m_phase = ph;
    end
  end

  bit stall = 1'b0;
  logic [11:0] ptx = '0;

  always @(negedge clk) begin : chk
    bit er;
    if (chk_en) begin
      er = (m_phase == 2) && (m_loads - m_pops < D);
      check("win_ready", win_ready, er);
      check("dp_load", dp_load, win_valid && er);
      check("busy", busy, m_phase != 0);
      check("frame_done", frame_done, m_phase == 4);
      check("dp_en", dp_en, m_en);
      check("dp_ar", dp_ar, m_ar);
      check("dp_ag", dp_ag, m_ag);
      check("dp_ab", dp_ab, m_ab);
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_tx", out_tx, ptx);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL out_spurious: got tx %0h, expected none",
                   out_tx);
        end else begin
          check("out_tx", out_tx, q[0]);
          check("out_last", out_last, m_oidx == FRAME - 1);
          void'(q.pop_front());
          m_oidx++;
          n_out++;
        end
      end
      stall = out_valid && !out_ready && rst_n;
      ptx = out_tx;
    end
  end

  typedef struct {
    logic rst_n, start, mode, av;
    logic [7:0] r, g, b;
    logic e_busy, e_wr, e_en;
    logic [7:0] e_r, e_g, e_b;
  } vec_t;

  vec_t tab[9];

  function automatic vec_t mk(int rs, int st, int md, int av,
                              int r, int g, int b, int eb,
                              int ew, int ee, int er,
                              int eg, int ebb);
    vec_t v;
    v.rst_n = 1'(rs); v.start = 1'(st);
    v.mode = 1'(md); v.av = 1'(av);
    v.r = 8'(r); v.g = 8'(g); v.b = 8'(b);
    v.e_busy = 1'(eb); v.e_wr = 1'(ew); v.e_en = 1'(ee);
    v.e_r = 8'(er); v.e_g = 8'(eg); v.e_b = 8'(ebb);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(int lim);
    for (int c = 0; c < lim && !frame_done; c++) tick();
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic begin_frame(logic md);
    n_out = 0;
    mode_en = md;
    a_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) pay[i] = 12'($urandom);
    tab[0] = mk(0,0,0,0,   0,  0,  0, 0,0,0,   0,  0,  0);
    tab[1] = mk(1,1,1,0,   0,  0,  0, 1,0,1,   0,  0,  0);
    for (int i = 2; i < 7; i++)
      tab[i] = mk(1,0,0,0, 0,  0,  0, 1,0,1,   0,  0,  0);
    tab[7] = mk(1,0,0,1, 200,150,100, 1,1,1, 200,150,100);
    tab[8] = mk(1,1,0,1,   1,  2,  3, 1,1,1, 200,150,100);

    for (int i = 0; i < 9; i++) begin
      rst_n = tab[i].rst_n;
      start = tab[i].start;
      mode_en = tab[i].mode;
      a_valid = tab[i].av;
      a_r = tab[i].r;
      a_g = tab[i].g;
      a_b = tab[i].b;
      tick();
      if (i == 0) chk_en = 1'b1;
      check($sformatf("v%0d_busy", i), busy, tab[i].e_busy);
      check($sformatf("v%0d_wr", i), win_ready, tab[i].e_wr);
      check($sformatf("v%0d_en", i), dp_en, tab[i].e_en);
      check($sformatf("v%0d_ar", i), dp_ar, tab[i].e_r);
      check($sformatf("v%0d_ag", i), dp_ag, tab[i].e_g);
      check($sformatf("v%0d_ab", i), dp_ab, tab[i].e_b);
    end
    a_valid = 1'b0;
    start = 1'b0;

    // Full frame, stray start with toggled mode mid-run
    n_out = 0;
    win_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && !frame_done; c++) begin
      start = (m_loads == 3);
      mode_en = 1'b0;
      tick();
    end
    start = 1'b0;
    check("f1_done", frame_done, 1);
    check("f1_outs", n_out, FRAME);
    check("f1_en_kept", dp_en, 1);
    tick();
    check("f1_done_pulse", frame_done, 0);
    check("f1_idle", busy, 0);

    // Stalled output: credits exhaust at FIFO depth
    out_ready = 1'b0;
    a_r = 8'd9;
    begin_frame(1'b0);
    for (int c = 0; c < 20; c++) tick();
    check("stall_loads", m_loads, D);
    check("stall_wr", win_ready, 0);
    out_ready = 1'b1;
    wait_done(300);
    check("stall_outs", n_out, FRAME);
    tick();

    // Reset mid-frame after three loads
    begin_frame(1'b1);
    for (int c = 0; c < 50 && m_loads < 3; c++) tick();
    rst_n = 1'b0;
    tick();
    check("rst_wr", win_ready, 0);
    check("rst_load", dp_load, 0);
    check("rst_en", dp_en, 0);
    check("rst_ar", dp_ar, 0);
    check("rst_ag", dp_ag, 0);
    check("rst_ab", dp_ab, 0);
    check("rst_ov", out_valid, 0);
    check("rst_tx", out_tx, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    rst_n = 1'b1;
    tick();
    begin_frame(1'b1);
    wait_done(300);
    check("rst_fresh_outs", n_out, FRAME);
    tick();

    // Random frames
    for (int f = 0; f < 8; f++) begin
      int dly;
      dly = int'($urandom_range(0, 6));
      n_out = 0;
      mode_en = 1'($urandom);
      a_valid = 1'b0;
      start = 1'b1;
      tick();
      for (int c = 0; c < 3000 && !frame_done; c++) begin
        a_valid = (c >= dly);
        a_r = 8'($urandom);
        a_g = 8'($urandom);
        a_b = 8'($urandom);
        win_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        start = ($urandom_range(0, 9) == 0);
        mode_en = 1'($urandom);
        tick();
      end
      start = 1'b0;
      check($sformatf("rnd%0d_done", f), frame_done, 1);
      check($sformatf("rnd%0d_outs", f), n_out, FRAME);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
